// File: rtl/sigmoid_q15_pkg.sv
// Shared Q1.15 constants and FSM state type for the sigmoid forward/inverse pair.
package sigmoid_q15_pkg;

    localparam logic signed [15:0] Q15_MIN      = 16'sh8000;
    localparam logic signed [15:0] Q15_MAX      = 16'sh7FFF;
    localparam int                 SIGINV_ITERS = 17;

    // Bisection bounds are 17-bit so that +32768 can act as the "nothing reaches y" sentinel.
    localparam logic signed [16:0] LO_INIT = -17'sd32768;
    localparam logic signed [16:0] HI_INIT = 17'sd32768;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } siginv_state_t;

endpackage

// File: rtl/sigmoid_approx_q15.sv
// Combinational piecewise-linear sigmoid: x in Q1.15 spans z = [-8, 8), result in Q1.15.
// Monotone non-decreasing; output saturates flat at 32752 (and 16 on the negative side).
module sigmoid_approx_q15 (
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic [16:0] mag_s;
    logic [16:0] seg3_s;
    logic [16:0] f_s;

    // Odd symmetry around 0.5: evaluate f(|x|) and mirror for negative inputs.
    always_comb begin
        mag_s  = x[15] ? (~{x[15], x} + 17'd1) : {1'b0, x};
        seg3_s = 17'd27776 + (mag_s >> 2);
        if (mag_s < 17'd4096) begin
            f_s = 17'd16384 + (mag_s << 1);
        end else if (mag_s < 17'd9728) begin
            f_s = 17'd20480 + mag_s;
        end else if (seg3_s > 17'd32752) begin
            f_s = 17'd32752;
        end else begin
            f_s = seg3_s;
        end
        if (x[15]) begin
            y = 16'(17'd32768 - f_s);
        end else begin
            y = 16'(f_s);
        end
    end

endmodule

// File: rtl/sigmoid_inv_q15.sv
// Bisection inverse of sigmoid_approx_q15: smallest x with sigmoid(x) >= y_in.
// Optional nearest-value rounding step enabled by SIGINV_ROUND_NEAREST_EN.
module sigmoid_inv_q15
    import sigmoid_q15_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] x_out,
    output logic               sat,
    output logic               busy
);

    siginv_state_t      state_q, state_d;
    logic signed [15:0] tgt_q, tgt_d;
    logic signed [16:0] lo_q, lo_d;
    logic signed [16:0] hi_q, hi_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [15:0] x_q, x_d;
    logic               sat_q, sat_d;

    logic signed [17:0] sum_s;
    logic signed [16:0] mid_s;
    logic signed [15:0] fwd_x_s;
    logic signed [15:0] fwd_y_s;

    assign sum_s = {lo_q[16], lo_q} + {hi_q[16], hi_q};
    assign mid_s = 17'(sum_s >>> 1);

`ifdef SIGINV_ROUND_NEAREST_EN
    logic signed [15:0] s_hi_q, s_hi_d;
    logic signed [15:0] lo_m1_s;
    logic signed [17:0] d_below_s;
    logic signed [17:0] d_above_s;

    // The single forward instance serves the bisection probe and the ROUND probe of lo-1.
    assign lo_m1_s   = 16'(lo_q - 17'sd1);
    assign fwd_x_s   = (state_q == ROUND) ? lo_m1_s : mid_s[15:0];
    assign d_below_s = {{2{tgt_q[15]}}, tgt_q} - {{2{fwd_y_s[15]}}, fwd_y_s};
    assign d_above_s = {{2{s_hi_q[15]}}, s_hi_q} - {{2{tgt_q[15]}}, tgt_q};
`else
    assign fwd_x_s = mid_s[15:0];
`endif

    sigmoid_approx_q15 u_fwd (
        .x (fwd_x_s),
        .y (fwd_y_s)
    );

    // Next-state, bisection update and result capture.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        sat_d   = sat_q;
`ifdef SIGINV_ROUND_NEAREST_EN
        s_hi_d  = s_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tgt_d   = y_in;
                    lo_d    = LO_INIT;
                    hi_d    = HI_INIT;
                    cnt_d   = 5'd0;
                    state_d = SEARCH;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                cnt_d = cnt_q + 5'd1;
                if (lo_q < hi_q) begin
                    if (fwd_y_s < tgt_q) begin
                        lo_d = mid_s + 17'sd1;
                    end else begin
                        hi_d = mid_s;
`ifdef SIGINV_ROUND_NEAREST_EN
                        s_hi_d = fwd_y_s;
`endif
                    end
                end else begin
                    lo_d = lo_q;
                end
                if (cnt_q == 5'(SIGINV_ITERS - 1)) begin
                    if (lo_d == HI_INIT) begin
                        x_d   = Q15_MAX;
                        sat_d = 1'b1;
                    end else begin
                        x_d   = lo_d[15:0];
                        sat_d = 1'b0;
                    end
`ifdef SIGINV_ROUND_NEAREST_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = SEARCH;
                end
            end
`ifdef SIGINV_ROUND_NEAREST_EN
            ROUND: begin
                state_d = DONE;
                // s_hi_q equals sigmoid(lo) here because the search has converged to lo == hi.
                if ((lo_q != LO_INIT) && !sat_q && (d_below_s < d_above_s)) begin
                    x_d = lo_m1_s;
                end else begin
                    x_d = x_q;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= 16'sd0;
            lo_q    <= 17'sd0;
            hi_q    <= 17'sd0;
            cnt_q   <= 5'd0;
            x_q     <= 16'sd0;
            sat_q   <= 1'b0;
`ifdef SIGINV_ROUND_NEAREST_EN
            s_hi_q  <= 16'sd0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            sat_q   <= sat_d;
`ifdef SIGINV_ROUND_NEAREST_EN
            s_hi_q  <= s_hi_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign x_out     = x_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_sigmoid_inv_q15.sv
// Directed + random bench for sigmoid_inv_q15 with a golden inverse table built by linear scan.
module tb_sigmoid_inv_q15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] y_in = 16'sd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] x_out;
    logic               sat;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef SIGINV_ROUND_NEAREST_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    typedef struct {
        int    x;
        int    sat;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   inv_tab[65536];

    sigmoid_inv_q15 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference forward curve: z = x/4096, value*32768, odd-symmetric about 0.5.
    function automatic int sig_ref(input int x);
        int a;
        int v;
        a = (x < 0) ? -x : x;
        if (a < 4096)       v = 16384 + a * 2;
        else if (a < 9728)  v = 20480 + a;
        else                v = 27776 + a / 4;
        if (v > 32752) v = 32752;
        return (x < 0) ? (32768 - v) : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int y, input string tag);
        exp_t e;
        int   lo;
        lo    = inv_tab[y + 32768];
        e.tag = tag;
        if (lo == 40000) begin
            e.x   = 32767;
            e.sat = 1;
        end else begin
            e.x   = lo;
            e.sat = 0;
`ifdef SIGINV_ROUND_NEAREST_EN
            if (lo > -32768) begin
                if ((y - sig_ref(lo - 1)) < (sig_ref(lo) - y)) e.x = lo - 1;
            end
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Accept one request and return when out_valid is high (or the bound expires); lat = cycles after accept.
    task automatic launch(input int y, input string tag, output int lat);
        sb.push_back(model(y, tag));
        wait_ready(tag);
        in_valid = 1'b1;
        y_in     = 16'(y);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_txn(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_lat"}, lat, LAT);
            chk({e.tag, "_x"}, int'(x_out), e.x);
            chk({e.tag, "_sat"}, int'(sat), e.sat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic txn(input int y, input string tag);
        int lat;
        launch(y, tag, lat);
        finish_txn(lat);
    endtask

    initial begin
        int prev;
        int s;
        int lat;
        int bad;
        logic signed [15:0] hold_x;
        logic               hold_sat;

        // Golden inverse by a single linear scan over all x of the monotone reference curve.
        for (int i = 0; i < 65536; i++) inv_tab[i] = 40000;
        prev = -32769;
        for (int x = -32768; x <= 32767; x++) begin
            s = sig_ref(x);
            for (int y = prev + 1; y <= s; y++) inv_tab[y + 32768] = x;
            if (s > prev) prev = s;
        end

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;
        tick();

        txn(-1, "neg_one");
        chk("tab_neg_one", inv_tab[-1 + 32768], -32768);
        txn(-32768, "most_neg");
        txn(16, "floor_val");
        txn(17, "above_floor");
        txn(16384, "sig_zero");
        chk("sig_zero_le0", int'(inv_tab[16384 + 32768] <= 0), 1);
        txn(32767, "sat_top");
        txn(32752, "sig_max");
        txn(24575, "tie_pt");
        txn(16385, "steep_step");
        txn(30300, "flat_seg");

        // Back-pressure: result must hold and input must be refused while DONE.
        launch(1000, "bp", lat);
        hold_x   = x_out;
        hold_sat = sat;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            y_in     = 16'sd5;
            tick();
            if (x_out !== hold_x || sat !== hold_sat || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        chk("bp_stable", bad, 0);
        finish_txn(lat);

        // Reset while cnt == 5: request is dropped without output.
        wait_ready("rst_mid");
        in_valid = 1'b1;
        y_in     = 16'sd20000;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        chk("midrst_no_output", bad, 0);

        for (int i = 0; i < 150; i++) begin
            txn(int'($signed(16'($urandom))), "rand");
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
